// File: rtl/sr_pkg.sv
// Shared definitions for the sr_cmd_gen command stage: FSM encoding,
// default timing constants and a counter-width helper.
package sr_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PULSE = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam int unsigned DEF_DB_CYCLES = 4;
   localparam int unsigned DEF_HOLDOFF   = 2;

   typedef enum logic [1:0] {
      StIdle  = ST_IDLE,
      StPulse = ST_PULSE,
      StHold  = ST_HOLD
   } sr_state_e;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_width(int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser followed by a counting debounce filter; flags the
// rising edge of the filtered level.
module sr_debounce
   import sr_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   output logic filt,
   output logic rise
);

   localparam int unsigned    CW       = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          filt_q;
   logic          filt_d;
   logic          filt_dly_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The level flips on the cycle the mismatch count would reach DB_CYCLES.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         filt_q     <= 1'b0;
         filt_dly_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= req;
         sync2_q    <= sync1_q;
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         cnt_q      <= cnt_d;
      end
   end

   assign filt = filt_q;
   assign rise = filt_q & ~filt_dly_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Command generator for sr_ff: debounced set/clear requests become spaced,
// mutually exclusive single-cycle s/r pulses, skipping already-satisfied ones.
module sr_cmd_gen
   import sr_pkg::*;
#(
   parameter int unsigned DB_CYCLES      = DEF_DB_CYCLES,
   parameter int unsigned HOLDOFF        = DEF_HOLDOFF,
   parameter int unsigned RESET_PRIORITY = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_req,
   input  logic clr_req,
   input  logic q_fb,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict
);

   localparam int unsigned   HW            = cnt_width(HOLDOFF);
   localparam int unsigned   HOLD_LAST_INT = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
   localparam logic [HW-1:0] HOLD_LAST     = HW'(HOLD_LAST_INT);

   logic          filt_s;
   logic          filt_c;
   logic          rise_s;
   logic          rise_c;
   logic          want_s;
   logic          want_c;
   logic          serve_s;
   logic          serve_c;

   sr_state_e     state_q;
   sr_state_e     state_d;
   logic          pend_s_q;
   logic          pend_s_d;
   logic          pend_c_q;
   logic          pend_c_d;
   logic          s_q;
   logic          s_d;
   logic          r_q;
   logic          r_d;
   logic          conflict_q;
   logic          conflict_d;
   logic [HW-1:0] hcnt_q;
   logic [HW-1:0] hcnt_d;

   sr_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db_set (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (set_req),
      .filt  (filt_s),
      .rise  (rise_s)
   );

   sr_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db_clr (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (clr_req),
      .filt  (filt_c),
      .rise  (rise_c)
   );

   assign want_s = pend_s_q | rise_s;
   assign want_c = pend_c_q | rise_c;

   always_comb begin
      state_d    = state_q;
      hcnt_d     = hcnt_q;
      s_d        = 1'b0;
      r_d        = 1'b0;
      conflict_d = 1'b0;
      serve_s    = 1'b0;
      serve_c    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (want_s && want_c) begin
               conflict_d = 1'b1;
               if (RESET_PRIORITY != 0) begin
                  serve_c = 1'b1;
               end else begin
                  serve_s = 1'b1;
               end
            end else if (want_s) begin
               serve_s = 1'b1;
            end else if (want_c) begin
               serve_c = 1'b1;
            end
            // A served request whose effect q already shows is dropped silently.
            if (serve_s && !q_fb) begin
               s_d     = 1'b1;
               state_d = StPulse;
            end
            if (serve_c && q_fb) begin
               r_d     = 1'b1;
               state_d = StPulse;
            end
         end
         StPulse: begin
            if (HOLDOFF > 0) begin
               state_d = StHold;
               hcnt_d  = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StHold: begin
            if (hcnt_q == HOLD_LAST) begin
               state_d = StIdle;
            end else begin
               hcnt_d = hcnt_q + HW'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      pend_s_d = want_s & ~serve_s;
      pend_c_d = want_c & ~serve_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         pend_s_q   <= 1'b0;
         pend_c_q   <= 1'b0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
         hcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         pend_s_q   <= pend_s_d;
         pend_c_q   <= pend_c_d;
         s_q        <= s_d;
         r_q        <= r_d;
         conflict_q <= conflict_d;
         hcnt_q     <= hcnt_d;
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign conflict = conflict_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen: three configurations share one stimulus
// stream and are compared cycle by cycle with a behavioural model.
module tb_sr_cmd_gen;

   localparam int DBV [3] = '{4, 4, 1};
   localparam int HOV [3] = '{2, 2, 6};
   localparam int PRV [3] = '{1, 0, 1};

   logic       clk;
   logic       rst_n;
   logic       set_req;
   logic       clr_req;
   logic [2:0] q;
   logic [2:0] s_w;
   logic [2:0] r_w;
   logic [2:0] busy_w;
   logic [2:0] conf_w;

   int n_tests;
   int n_fail;

   // Reference model state; index [k][0] is the set input, [k][1] the clear input.
   logic m_s1  [3][2];
   logic m_s2  [3][2];
   logic m_f   [3][2];
   logic m_fd  [3][2];
   logic m_p   [3][2];
   int   m_c   [3][2];
   int   m_busy[3];
   logic m_s   [3];
   logic m_r   [3];
   logic m_conf[3];

   sr_cmd_gen #(.DB_CYCLES(4), .HOLDOFF(2), .RESET_PRIORITY(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .q_fb(q[0]),
      .s(s_w[0]), .r(r_w[0]), .busy(busy_w[0]), .conflict(conf_w[0])
   );
   sr_cmd_gen #(.DB_CYCLES(4), .HOLDOFF(2), .RESET_PRIORITY(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .q_fb(q[1]),
      .s(s_w[1]), .r(r_w[1]), .busy(busy_w[1]), .conflict(conf_w[1])
   );
   sr_cmd_gen #(.DB_CYCLES(1), .HOLDOFF(6), .RESET_PRIORITY(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .q_fb(q[2]),
      .s(s_w[2]), .r(r_w[2]), .busy(busy_w[2]), .conflict(conf_w[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advances the model over the coming edge using the values the DUTs will sample.
   task automatic model_step();
      logic inp [2];
      logic rise[2];
      logic want[2];
      int   side;
      inp[0] = set_req;
      inp[1] = clr_req;
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
               m_s1[k][j] = 1'b0; m_s2[k][j] = 1'b0; m_f[k][j] = 1'b0;
               m_fd[k][j] = 1'b0; m_p[k][j]  = 1'b0; m_c[k][j] = 0;
            end
            m_busy[k] = 0; m_s[k] = 1'b0; m_r[k] = 1'b0; m_conf[k] = 1'b0;
         end else begin
            for (int j = 0; j < 2; j++) begin
               rise[j] = m_f[k][j] & ~m_fd[k][j];
               want[j] = m_p[k][j] | rise[j];
            end
            m_s[k] = 1'b0; m_r[k] = 1'b0; m_conf[k] = 1'b0;
            side = -1;
            if (m_busy[k] == 0) begin
               if (want[0] && want[1]) begin
                  m_conf[k] = 1'b1;
                  side = (PRV[k] != 0) ? 1 : 0;
               end else if (want[0]) side = 0;
               else if (want[1]) side = 1;
               if (side == 0) begin
                  want[0] = 1'b0;
                  if (!q[k]) begin m_s[k] = 1'b1; m_busy[k] = 1 + HOV[k]; end
               end else if (side == 1) begin
                  want[1] = 1'b0;
                  if (q[k]) begin m_r[k] = 1'b1; m_busy[k] = 1 + HOV[k]; end
               end
            end else begin
               m_busy[k] = m_busy[k] - 1;
            end
            for (int j = 0; j < 2; j++) begin
               m_p[k][j]  = want[j];
               m_fd[k][j] = m_f[k][j];
               if (m_s2[k][j] != m_f[k][j]) begin
                  m_c[k][j] = m_c[k][j] + 1;
                  if (m_c[k][j] == DBV[k]) begin
                     m_f[k][j] = m_s2[k][j];
                     m_c[k][j] = 0;
                  end
               end else begin
                  m_c[k][j] = 0;
               end
               m_s2[k][j] = m_s1[k][j];
               m_s1[k][j] = inp[j];
            end
         end
      end
   endtask

   // One clock: model update, downstream sr_ff update, then settle #1 past the edge.
   task automatic tick();
      logic [2:0] qn;
      model_step();
      for (int k = 0; k < 3; k++) qn[k] = s_w[k] ? 1'b1 : (r_w[k] ? 1'b0 : q[k]);
      @(posedge clk);
      #1;
      q = qn;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [3:0] exp_vec(input int k);
      return {m_s[k], m_r[k], (m_busy[k] != 0), m_conf[k]};
   endfunction

   function automatic logic [3:0] obs_vec(input int k);
      return {s_w[k], r_w[k], busy_w[k], conf_w[k]};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      for (int e = 0; e < 3; e++) begin
         tick();
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_vec(k) !== 4'b0000 || exp_vec(k) !== 4'b0000) begin
               n_fail++;
               $display("FAIL reset[%0d] got s,r,busy,conf=%b want 0000", k, obs_vec(k));
            end
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_clean_set();
      q = 3'b000;
      set_req = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_tests++;
         if (s_w[0] !== (e == 7) || busy_w[0] !== (e >= 7 && e <= 9) || r_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_set e=%0d got s=%b busy=%b r=%b want s=%b busy=%b r=0",
                     e, s_w[0], busy_w[0], r_w[0], e == 7, e >= 7 && e <= 9);
         end
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_vec(k) !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL clean_set_model[%0d] e=%0d got %b want %b",
                        k, e, obs_vec(k), exp_vec(k));
            end
         end
      end
      set_req = 1'b0;
      idle(12);
   endtask

   task automatic test_bounce();
      q = 3'b000;
      for (int e = 0; e < 8; e++) begin
         set_req = ((e / 2) % 2 == 0);
         tick();
         n_tests++;
         if (s_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_quiet e=%0d got s=%b want 0", e, s_w[0]);
         end
      end
      set_req = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_tests++;
         if (s_w[0] !== (e == 7)) begin
            n_fail++;
            $display("FAIL bounce_settle e=%0d got s=%b want %b", e, s_w[0], e == 7);
         end
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_vec(k) !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL bounce_model[%0d] e=%0d got %b want %b",
                        k, e, obs_vec(k), exp_vec(k));
            end
         end
      end
      set_req = 1'b0;
      idle(12);
   endtask

   task automatic test_suppress();
      q = 3'b111;
      set_req = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_tests++;
         if (s_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL suppress_set e=%0d got s=%b busy=%b want 0 0", e, s_w[0], busy_w[0]);
         end
      end
      clr_req = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_tests++;
         if (r_w[0] !== (e == 7) || s_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL suppress_clr e=%0d got r=%b s=%b want r=%b s=0",
                     e, r_w[0], s_w[0], e == 7);
         end
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_vec(k) !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL suppress_model[%0d] e=%0d got %b want %b",
                        k, e, obs_vec(k), exp_vec(k));
            end
         end
      end
      set_req = 1'b0;
      clr_req = 1'b0;
      idle(12);
   endtask

   task automatic test_conflict();
      logic [3:0] want0;
      logic [3:0] want1;
      q = 3'b101;
      set_req = 1'b1;
      clr_req = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         tick();
         // {s, r, conflict}: r wins on the priority-1 unit, s on the priority-0 unit.
         want0 = {e == 11, e == 7, e == 7, 1'b0};
         want1 = {e == 7, e == 11, e == 7, 1'b0};
         n_tests++;
         if ({s_w[0], r_w[0], conf_w[0]} !== want0[3:1]) begin
            n_fail++;
            $display("FAIL conflict_p1 e=%0d got s,r,conf=%b want %b",
                     e, {s_w[0], r_w[0], conf_w[0]}, want0[3:1]);
         end
         n_tests++;
         if ({s_w[1], r_w[1], conf_w[1]} !== want1[3:1]) begin
            n_fail++;
            $display("FAIL conflict_p0 e=%0d got s,r,conf=%b want %b",
                     e, {s_w[1], r_w[1], conf_w[1]}, want1[3:1]);
         end
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_vec(k) !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL conflict_model[%0d] e=%0d got %b want %b",
                        k, e, obs_vec(k), exp_vec(k));
            end
         end
      end
      set_req = 1'b0;
      clr_req = 1'b0;
      idle(12);
   endtask

   // Fast-filter unit: s at edge 4, two clear rises inside its 6-cycle hold, one r at 12.
   task automatic test_holdoff_merge();
      int r_cnt;
      q = 3'b000;
      r_cnt = 0;
      set_req = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         clr_req = ((e >= 4 && e <= 5) || e >= 8);
         tick();
         r_cnt += int'(r_w[2]);
         n_tests++;
         if (s_w[2] !== (e == 4) || r_w[2] !== (e == 12)) begin
            n_fail++;
            $display("FAIL holdoff_merge e=%0d got s=%b r=%b want s=%b r=%b",
                     e, s_w[2], r_w[2], e == 4, e == 12);
         end
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_vec(k) !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL holdoff_model[%0d] e=%0d got %b want %b",
                        k, e, obs_vec(k), exp_vec(k));
            end
         end
      end
      n_tests++;
      if (r_cnt != 1) begin
         n_fail++;
         $display("FAIL holdoff_merge_count got %0d r pulses want 1", r_cnt);
      end
      set_req = 1'b0;
      clr_req = 1'b0;
      idle(12);
   endtask

   task automatic test_reset_mid_pulse();
      q = 3'b000;
      set_req = 1'b1;
      idle(7);
      n_tests++;
      if (s_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pulse_pre got s=%b want 1", s_w[0]);
      end
      rst_n = 1'b0;
      set_req = 1'b0;
      tick();
      rst_n = 1'b1;
      n_tests++;
      if ({s_w, r_w, busy_w, conf_w} !== 12'h000) begin
         n_fail++;
         $display("FAIL mid_pulse_reset got s=%b r=%b busy=%b conf=%b want all 0",
                  s_w, r_w, busy_w, conf_w);
      end
      for (int e = 1; e <= 15; e++) begin
         tick();
         n_tests++;
         if ((s_w | r_w) !== 3'b000 || obs_vec(0) !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL mid_pulse_after e=%0d got s=%b r=%b want 0", e, s_w, r_w);
         end
      end
   endtask

   task automatic test_random();
      int hold_s;
      int hold_c;
      hold_s = 0;
      hold_c = 0;
      for (int e = 0; e < 800; e++) begin
         if (hold_s == 0) begin set_req = $urandom_range(0, 1); hold_s = $urandom_range(1, 12); end
         if (hold_c == 0) begin clr_req = $urandom_range(0, 1); hold_c = $urandom_range(1, 12); end
         hold_s--;
         hold_c--;
         if ($urandom_range(0, 31) == 0) q[$urandom_range(0, 2)] = $urandom_range(0, 1);
         rst_n = ($urandom_range(0, 299) != 0);
         tick();
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_vec(k) !== exp_vec(k) || (s_w[k] & r_w[k]) !== 1'b0) begin
               n_fail++;
               $display("FAIL random_model[%0d] e=%0d got %b want %b",
                        k, e, obs_vec(k), exp_vec(k));
            end
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      set_req = 1'b0;
      clr_req = 1'b0;
      q       = 3'b000;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 2; j++) begin
            m_s1[k][j] = 1'b0; m_s2[k][j] = 1'b0; m_f[k][j] = 1'b0;
            m_fd[k][j] = 1'b0; m_p[k][j]  = 1'b0; m_c[k][j] = 0;
         end
         m_busy[k] = 0; m_s[k] = 1'b0; m_r[k] = 1'b0; m_conf[k] = 1'b0;
      end
      #2;
      test_reset();
      test_clean_set();
      test_bounce();
      test_suppress();
      test_conflict();
      test_holdoff_merge();
      test_reset_mid_pulse();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for sr_ff.
- Takes two raw, asynchronous, bouncy request lines (set_req, clr_req) and synchronises and debounces them.
- Turns each debounced rising edge into a single-cycle s or r pulse, which drives sr_ff directly.
- Guarantees s and r are never both 1, spaces pulses by a hold-off window, and suppresses commands already satisfied by sr_ff's q (fed back on q_fb).

Parameters:
- DB_CYCLES, 4, consecutive cycles a synchronised input must differ from its filtered level before the filtered level flips (>=1).
- HOLDOFF, 2, idle cycles forced after each pulse before the next may issue (>=0).
- RESET_PRIORITY, 1, on a simultaneous set/clear conflict: 1 = r wins, 0 = s wins.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- set_req  in  1  raw set request, asynchronous, may bounce.
- clr_req  in  1  raw clear request, asynchronous, may bounce.
- q_fb  in  1  q output of the downstream sr_ff.
- s  out  1  registered set pulse to sr_ff.
- r  out  1  registered reset pulse to sr_ff.
- busy  out  1  high in PULSE and HOLD states.
- conflict  out  1  one-cycle pulse when both requests compete in the same IDLE decision.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n: sampled only on posedge clk, and active when 0.
- Reset state: s=0, r=0, busy=0, conflict=0. Sync flops 0, filtered levels 0, debounce counters 0, pending flags 0, state IDLE.
- Reset mid-operation (any state, including mid-pulse): the same clear applies on that edge. s and r are 0 from the next cycle.
- Synchroniser: two flops per input (sync1, sync2).
- Debounce, per input:
  - When sync2 != filt, cnt increments each cycle.
  - When cnt would reach DB_CYCLES, filt <= sync2 and cnt <= 0.
  - When sync2 == filt, cnt <= 0. Any glitch shorter than DB_CYCLES is therefore rejected.
- Edge detect: rise_x = filt_x & ~filt_x_d (filt_x_d is filt_x registered one cycle). Only rising edges produce commands; falling edges are ignored.
- Pending flags pend_s and pend_c:
  - Set by rise_x in any state. Repeated rises merge, with no queue depth beyond 1.
  - Cleared when serviced or suppressed.
- FSM: IDLE, PULSE, HOLD. Let want_s = pend_s|rise_s and want_c = pend_c|rise_c.
  - IDLE, only want_s: if q_fb=1, suppress (clear pend_s, no pulse, stay IDLE). Else s<=1, clear pend_s, go to PULSE.
  - IDLE, only want_c: same as above, using q_fb=0 for suppression and r for the pulse.
  - IDLE, both wanted: conflict<=1 for one cycle. Serve the priority side per RESET_PRIORITY (suppression rule still applies). Clear only the served side's pending flag; the other stays pending.
  - PULSE: s and r return to 0 at the next edge. If HOLDOFF>0, go to HOLD with hcnt<=0; else go to IDLE.
  - HOLD: hcnt increments each cycle. When hcnt==HOLDOFF-1, go to IDLE. No pulse is issued in HOLD; new rises only set pending flags.
- Output rules:
  - s and r are each high for exactly one cycle per pulse.
  - The invariant !(s&r) holds at all times.
- Latency, clean input: s (or r) goes high at posedge number DB_CYCLES+3 after the first posedge that samples set_req=1 (or clr_req=1). This is posedge 7 for the defaults.
- After reset release: an input held high during reset is debounced normally and yields one command.
- Back-to-back minimum spacing between pulses: 1+HOLDOFF+1 cycles from one pulse's rising edge to the next.

Decomposition:
- Shared package sr_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_PULSE=2'd1, ST_HOLD=2'd2;
  - default DB_CYCLES and HOLDOFF constants.
- One sub-module, sr_debounce (synchroniser + counter + filt + rise output), instantiated twice with parameter DB_CYCLES. The FSM, pending flags and hold-off counter stay in sr_cmd_gen.

Test Plan:
- Reset, clean set: hold rst_n=0 for 3 cycles, then set_req=1 with q_fb=0 and defaults. Required: s=1 for exactly one cycle at posedge 7 after the first sampling edge; busy high for 1+2 cycles; r=0 throughout.
- Bounce rejection: set_req toggles 1,0,1,0 every 2 cycles, then settles at 1. Required: exactly one s pulse, issued DB_CYCLES+3 edges after settling; no pulse during the bounce.
- Suppression: q_fb=1, raise set_req. Required: no s pulse and busy stays 0. Then raise clr_req. Required: r pulse once.
- Conflict: set_req and clr_req rise on the same edge with q_fb toggled appropriately by a model sr_ff.
  - RESET_PRIORITY=1: r pulses first with conflict=1 for one cycle, then s pulses 4 cycles later (after PULSE + 2 HOLD).
  - RESET_PRIORITY=0: s pulses first, then r.
- Hold-off merge: during HOLD, a clr rise arrives twice. Required: exactly one r pulse, on the cycle after HOLD ends.
- Reset mid-pulse: assert rst_n=0 in the cycle s=1. Required: s=0 the next cycle, all pending flags cleared, no pulse after release while inputs are 0.
